// File: rtl/draw_square.sv
// rtl/draw_square.sv - rasterises one square request into single-pixel VGA writes
module draw_square #(
    parameter int         SQUARE_W = 4,
    parameter int         SQUARE_H = 4,
    parameter logic [6:0] ROW_Y    = 7'd60,
    parameter logic [7:0] X_MAX    = 8'd159
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] square_x,
    input  logic [2:0] colour,
    output logic       ready,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAW   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [2:0] DX_LAST = 3'(SQUARE_W - 1);
    localparam logic [2:0] DY_LAST = 3'(SQUARE_H - 1);

    state_t     state_q, state_d;
    logic [7:0] x_lat_q, x_lat_d;
    logic [2:0] colour_lat_q, colour_lat_d;
    logic [2:0] dx_q, dx_d;
    logic [2:0] dy_q, dy_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       plot_q, plot_d;
    logic       done_q, done_d;

    logic       draw_en;
    logic [7:0] pix_base;
    logic [2:0] pix_col;
    logic [8:0] pix_sum;

    always_comb begin
        state_d      = state_q;
        x_lat_d      = x_lat_q;
        colour_lat_d = colour_lat_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        plot_d       = 1'b0;
        done_d       = 1'b0;
        draw_en      = 1'b0;
        pix_base     = x_lat_q;
        pix_col      = colour_lat_q;
        pix_sum      = 9'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // First pixel is registered on the accept edge so plot rises next cycle
                    state_d      = DRAW;
                    x_lat_d      = square_x;
                    colour_lat_d = colour;
                    dx_d         = 3'd0;
                    dy_d         = 3'd0;
                    draw_en      = 1'b1;
                    pix_base     = square_x;
                    pix_col      = colour;
                end
            end
            DRAW: begin
                if (dx_q == DX_LAST && dy_q == DY_LAST) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else begin
                    draw_en = 1'b1;
                    if (dx_q == DX_LAST) begin
                        dx_d = 3'd0;
                        dy_d = dy_q + 3'd1;
                    end else begin
                        dx_d = dx_q + 3'd1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (draw_en) begin
            // 9-bit sum so columns past X_MAX are clipped rather than wrapped
            pix_sum      = {1'b0, pix_base} + {6'b0, dx_d};
            vga_x_d      = pix_sum[7:0];
            vga_y_d      = ROW_Y + {4'b0, dy_d};
            vga_colour_d = pix_col;
            plot_d       = (pix_sum <= {1'b0, X_MAX});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_lat_q      <= 8'd0;
            colour_lat_q <= 3'd0;
            dx_q         <= 3'd0;
            dy_q         <= 3'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_lat_q      <= x_lat_d;
            colour_lat_q <= colour_lat_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;
    assign done       = done_q;

endmodule

// File: tb/tb_draw_square.sv
// tb/tb_draw_square.sv - table, directed and randomized checks of draw_square
module tb_draw_square;

    localparam int NPIX = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] square_x;
    logic [2:0] colour;
    logic       ready;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       done;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int done_seen = 0;

    draw_square dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .square_x   (square_x),
        .colour     (colour),
        .ready      (ready),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .done       (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done === 1'b1) done_seen++;

    typedef struct {
        logic [7:0] sx;
        logic [2:0] col;
        int         exp_plots;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at the first negedge after the accept edge; returns at the IDLE cycle after FINISH.
    task automatic check_square(input logic [7:0] sx, input logic [2:0] col,
                                input int intrude, output int plots);
        int px;
        plots = 0;
        for (int c = 1; c <= NPIX + 2; c++) begin
            if (c <= NPIX) begin
                px = int'(sx) + (c - 1) % 4;
                chk("pix_plot", plot, (px <= 159) ? 1 : 0);
                chk("pix_done", done, 0);
                chk("pix_ready", ready, 0);
                if (plot === 1'b1) plots++;
                if (px <= 159) begin
                    chk("pix_x", vga_x, px);
                    chk("pix_y", vga_y, 60 + (c - 1) / 4);
                    chk("pix_col", vga_colour, col);
                end
            end else if (c == NPIX + 1) begin
                chk("fin_done", done, 1);
                chk("fin_plot", plot, 0);
                chk("fin_ready", ready, 0);
            end else begin
                chk("idle_ready", ready, 1);
                chk("idle_done", done, 0);
                chk("idle_plot", plot, 0);
            end
            if (intrude != 0 && c == intrude) begin
                start = 1'b1; square_x = 8'd45; colour = 3'b010;
            end else if (intrude != 0 && c == intrude + 1) begin
                start = 1'b0;
            end
            if (c < NPIX + 2) @(negedge clock);
        end
    endtask

    task automatic issue(input logic [7:0] sx, input logic [2:0] col);
        start = 1'b1; square_x = sx; colour = col;
        @(negedge clock);
        start = 1'b0;
    endtask

    vec_t vecs[8];

    int        m_phase;
    logic [7:0] m_x;
    logic [2:0] m_col;

    initial begin
        int plots;
        int d0;
        int px;
        int k;

        vecs[0] = '{8'd10,  3'b100, 16};
        vecs[1] = '{8'd157, 3'b100, 12};
        vecs[2] = '{8'd0,   3'b100, 16};
        vecs[3] = '{8'd25,  3'b000, 16};
        vecs[4] = '{8'd156, 3'b111, 16};
        vecs[5] = '{8'd158, 3'b001, 8};
        vecs[6] = '{8'd159, 3'b010, 4};
        vecs[7] = '{8'd200, 3'b101, 0};

        reset = 1'b1; start = 1'b0; square_x = 8'd0; colour = 3'd0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_plot", plot, 0);
        chk("rst_done", done, 0);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_vga_col", vga_colour, 0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].sx, vecs[i].col);
            check_square(vecs[i].sx, vecs[i].col, 0, plots);
            chk("tbl_plot_count", plots, vecs[i].exp_plots);
        end

        // start pulsed mid-draw must be ignored and not queued
        d0 = done_seen;
        issue(8'd0, 3'b100);
        check_square(8'd0, 3'b100, 3, plots);
        for (int i = 0; i < 5; i++) begin
            chk("ignored_plot", plot, 0);
            chk("ignored_ready", ready, 1);
            @(negedge clock);
        end
        chk("ignored_done_cnt", done_seen - d0, 1);

        // start held high: back-to-back squares
        d0 = done_seen;
        start = 1'b1; square_x = 8'd0; colour = 3'b110;
        @(negedge clock);
        check_square(8'd0, 3'b110, 0, plots);
        square_x = 8'd5;
        @(negedge clock);
        check_square(8'd5, 3'b110, 0, plots);
        square_x = 8'd10;
        @(negedge clock);
        check_square(8'd10, 3'b110, 0, plots);
        start = 1'b0;
        @(negedge clock);
        chk("held_done_cnt", done_seen - d0, 3);
        chk("held_ready_after", ready, 1);

        // reset at the 7th pixel
        d0 = done_seen;
        issue(8'd10, 3'b100);
        for (int c = 1; c < 7; c++) @(negedge clock);
        chk("mid_plot", plot, 1);
        chk("mid_x", vga_x, 12);
        chk("mid_y", vga_y, 61);
        reset = 1'b1;
        #1;
        chk("mr_plot", plot, 0);
        chk("mr_ready", ready, 1);
        chk("mr_x", vga_x, 0);
        chk("mr_y", vga_y, 0);
        chk("mr_col", vga_colour, 0);
        chk("mr_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mr_no_done", done_seen - d0, 0);
        issue(8'd20, 3'b011);
        check_square(8'd20, 3'b011, 0, plots);
        chk("mr_full_square", plots, 16);

        // randomized traffic against a phase model: -1 idle, 0..15 pixel index, 16 finish
        start = 1'b0;
        m_phase = -1; m_x = 8'd0; m_col = 3'd0;
        for (int n = 0; n < 1500; n++) begin
            chk("rnd_ready", ready, (m_phase == -1) ? 1 : 0);
            chk("rnd_done", done, (m_phase == NPIX) ? 1 : 0);
            if (m_phase >= 0 && m_phase < NPIX) begin
                k  = m_phase;
                px = int'(m_x) + k % 4;
                chk("rnd_plot", plot, (px <= 159) ? 1 : 0);
                if (px <= 159) begin
                    chk("rnd_x", vga_x, px);
                    chk("rnd_y", vga_y, 60 + k / 4);
                    chk("rnd_col", vga_colour, m_col);
                end
            end else begin
                chk("rnd_plot_idle", plot, 0);
            end
            start    = ($urandom_range(0, 3) == 0);
            square_x = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(150, 200))
                                                   : 8'($urandom_range(0, 255));
            colour   = 3'($urandom_range(0, 7));
            if (m_phase == -1) begin
                if (start) begin
                    m_phase = 0; m_x = square_x; m_col = colour;
                end
            end else if (m_phase < NPIX) begin
                m_phase++;
            end else begin
                m_phase = -1;
            end
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
